// File: rtl/frost32_mem_arbiter_if.sv
// Signal bundle between the Frost32 requesters (fetch and load/store), the arbiter and memory.
// The master modport is the arbiter's view. The slave modport is the view from the pipeline and memory.
interface frost32_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_access_type;
  logic [1:0]            d_access_size;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_access_type;
  logic [1:0]            mem_access_size;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_access_type, d_access_size,
    input  mem_rdata, mem_ack,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
    output mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size
  );

  modport slave (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_access_type, d_access_size,
    output mem_rdata, mem_ack,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
    input  mem_req, mem_addr, mem_wdata, mem_access_type, mem_access_size
  );
endinterface

// File: rtl/frost32_mem_arbiter.sv
// Round-robin arbiter that shares the single Frost32 memory bus between instruction fetch and
// load/store. It allows one transaction in flight and checks alignment and bus timeout.
module frost32_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   rst_n,
  frost32_mem_arbiter_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax     = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

  state_e                state_q;
  logic                  last_data_q;  // 0: fetch was granted last
  logic [CntW-1:0]       cnt_q;
  logic                  if_ack_q, d_ack_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mem_req_q, mem_type_q;
  logic [1:0]            mem_size_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  grant_data, grant_err, timeout_hit;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [CntW-1:0]       cnt_inc;

  always_comb begin
    grant_data = bus.d_req && (!bus.if_req || !last_data_q);
    gnt_addr   = grant_data ? bus.d_addr : bus.if_addr;
    grant_err  = 1'b0;
    if (grant_data) begin
      unique case (bus.d_access_size)
        2'd0:    grant_err = (gnt_addr[1:0] != 2'b00);
        2'd1:    grant_err = gnt_addr[0];
        2'd2:    grant_err = 1'b0;
        default: grant_err = 1'b1;
      endcase
    end else begin
      grant_err = (gnt_addr[1:0] != 2'b00);
    end
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_data_q <= 1'b0;
      cnt_q       <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_type_q  <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            last_data_q <= grant_data;
            mem_addr_q  <= gnt_addr;
            mem_wdata_q <= grant_data ? bus.d_wdata : '0;
            mem_type_q  <= grant_data ? bus.d_access_type : 1'b0;
            mem_size_q  <= grant_data ? bus.d_access_size : 2'd0;
            cnt_q       <= '0;
            if (grant_err) begin
              // Rejected on the spot: acknowledge without ever touching memory.
              if_ack_q <= !grant_data;
              d_ack_q  <= grant_data;
              err_q    <= 1'b1;
              rdata_q  <= '0;
              state_q  <= StResp;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= grant_data ? StData : StFetch;
            end
          end
        end
        StFetch, StData: begin
          // A completion in the same cycle as the timeout takes priority.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            rdata_q   <= (state_q == StData && mem_type_q) ? '0 : bus.mem_rdata;
            err_q     <= 1'b0;
            if_ack_q  <= (state_q == StFetch);
            d_ack_q   <= (state_q == StData);
            state_q   <= StResp;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            if_ack_q  <= (state_q == StFetch);
            d_ack_q   <= (state_q == StData);
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StResp: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.if_ack          = if_ack_q;
  assign bus.if_rdata        = rdata_q;
  assign bus.if_err          = err_q;
  assign bus.d_ack           = d_ack_q;
  assign bus.d_rdata         = rdata_q;
  assign bus.d_err           = err_q;
  assign bus.mem_req         = mem_req_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.mem_access_type = mem_type_q;
  assign bus.mem_access_size = mem_size_q;

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Directed bench for frost32_mem_arbiter: grant order, alignment errors, timeout, reset abort.
// One instance uses a 4-cycle timeout and a second instance has the timeout disabled.
module tb_frost32_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  always #5 clk = ~clk;

  frost32_mem_arbiter_if bus ();
  frost32_mem_arbiter_if bus0 ();

  frost32_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  frost32_mem_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.if_req = 0;  bus.if_addr = 0;  bus.d_req = 0;  bus.d_addr = 0;  bus.d_wdata = 0;
    bus.d_access_type = 0;  bus.d_access_size = 0;  bus.mem_rdata = 0;  bus.mem_ack = 0;
    bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_addr = 0; bus0.d_wdata = 0;
    bus0.d_access_type = 0; bus0.d_access_size = 0; bus0.mem_rdata = 0; bus0.mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_ack", bus.if_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;

    // Fetch only, mem_ack in cycle 3
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    chk("t1_mreq_c1", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_type", bus.mem_access_type, 0);
    chk("t1_size", bus.mem_access_size, 0);
    tick();
    chk("t1_mreq_c2", bus.mem_req, 1);
    tick();
    chk("t1_mreq_c3", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_if_ack", bus.if_ack, 1);
    chk("t1_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("t1_if_err", bus.if_err, 0);
    chk("t1_mreq_c4", bus.mem_req, 0);
    bus.mem_ack = 0; bus.if_req = 0;
    tick();
    chk("t1_if_ack_pulse", bus.if_ack, 0);

    // Tie with last grant = fetch: data wins
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.d_req = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    bus.d_access_type = 1; bus.d_access_size = 0;
    tick();
    chk("t2_mreq", bus.mem_req, 1);
    chk("t2_addr_data", bus.mem_addr, 32'h200);
    chk("t2_wdata", bus.mem_wdata, 32'h12345678);
    chk("t2_type", bus.mem_access_type, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    chk("t2_d_ack", bus.d_ack, 1);
    chk("t2_no_if_ack", bus.if_ack, 0);
    chk("t2_store_rdata", bus.d_rdata, 0);
    bus.mem_ack = 0; bus.d_req = 0;
    tick();
    tick();
    chk("t2_fetch_addr", bus.mem_addr, 32'h104);
    chk("t2_fetch_wdata", bus.mem_wdata, 0);
    chk("t2_fetch_type", bus.mem_access_type, 0);
    bus.mem_ack = 1; bus.mem_rdata = 32'h11112222;
    tick();
    chk("t2_if_ack", bus.if_ack, 1);
    chk("t2_if_rdata", bus.if_rdata, 32'h11112222);
    bus.mem_ack = 0; bus.if_req = 0;
    tick();
    // Byte load at an odd address is legal
    bus.d_req = 1; bus.d_addr = 32'h203; bus.d_access_type = 0; bus.d_access_size = 2;
    tick();
    chk("t2_byte_mreq", bus.mem_req, 1);
    chk("t2_byte_size", bus.mem_access_size, 2);
    bus.mem_ack = 1; bus.mem_rdata = 32'h000000AB;
    tick();
    chk("t2_byte_rdata", bus.d_rdata, 32'h000000AB);
    bus.mem_ack = 0; bus.d_req = 0;
    tick();
    // Tie with last grant = data: fetch wins
    bus.if_req = 1; bus.if_addr = 32'h108;
    bus.d_req = 1; bus.d_addr = 32'h20C; bus.d_access_size = 0;
    tick();
    chk("t2_tie2_addr", bus.mem_addr, 32'h108);
    bus.mem_ack = 1; bus.mem_rdata = 32'h33334444;
    tick();
    chk("t2_tie2_if_ack", bus.if_ack, 1);
    chk("t2_tie2_d_ack", bus.d_ack, 0);
    bus.mem_ack = 0; bus.if_req = 0;
    tick();
    tick();
    chk("t2_tie2_data_addr", bus.mem_addr, 32'h20C);
    bus.mem_ack = 1; bus.mem_rdata = 32'h55556666;
    tick();
    chk("t2_tie2_d_rdata", bus.d_rdata, 32'h55556666);
    bus.mem_ack = 0; bus.d_req = 0;
    tick();

    // Bad accesses are rejected without a memory request
    bus.mem_rdata = 32'hFFFFFFFF;
    bus.d_req = 1; bus.d_addr = 32'h201; bus.d_access_size = 1;
    tick();
    chk("t3_h_mreq", bus.mem_req, 0);
    chk("t3_h_ack", bus.d_ack, 1);
    chk("t3_h_err", bus.d_err, 1);
    chk("t3_h_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    tick();
    chk("t3_h_pulse", bus.d_ack, 0);
    tick();
    bus.d_req = 1; bus.d_addr = 32'h200; bus.d_access_size = 3;
    tick();
    chk("t3_bad_mreq", bus.mem_req, 0);
    chk("t3_bad_ack", bus.d_ack, 1);
    chk("t3_bad_err", bus.d_err, 1);
    bus.d_req = 0;
    tick();
    tick();
    bus.d_req = 1; bus.d_addr = 32'h202; bus.d_access_size = 0; bus.d_access_type = 1;
    tick();
    chk("t3_w32_err", bus.d_err, 1);
    chk("t3_w32_mreq", bus.mem_req, 0);
    bus.d_req = 0; bus.d_access_type = 0;
    tick();
    tick();
    bus.if_req = 1; bus.if_addr = 32'h102;
    tick();
    chk("t3_if_ack", bus.if_ack, 1);
    chk("t3_if_err", bus.if_err, 1);
    chk("t3_if_mreq", bus.mem_req, 0);
    bus.if_req = 0;
    tick();
    tick();

    // Timeout after 4 cycles of mem_req
    bus.if_req = 1; bus.if_addr = 32'h0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t4_mreq_c%0d", i), bus.mem_req, 1);
    end
    tick();
    chk("t4_mreq_drop", bus.mem_req, 0);
    chk("t4_if_ack", bus.if_ack, 1);
    chk("t4_if_err", bus.if_err, 1);
    chk("t4_if_rdata", bus.if_rdata, 0);
    bus.if_req = 0;
    tick();
    tick();

    // Timeout disabled: request held for 1000 cycles
    bus0.if_req = 1; bus0.if_addr = 32'h40;
    tick();
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus0.mem_req !== 1'b1) cnt++;
      tick();
    end
    chk("t4b_low_cycles", cnt, 0);
    chk("t4b_mreq_still", bus0.mem_req, 1);
    bus0.mem_ack = 1; bus0.mem_rdata = 32'h77778888;
    tick();
    chk("t4b_if_ack", bus0.if_ack, 1);
    chk("t4b_if_err", bus0.if_err, 0);
    chk("t4b_if_rdata", bus0.if_rdata, 32'h77778888);
    bus0.mem_ack = 0; bus0.if_req = 0;
    tick();

    // Reset while a load is in flight
    bus.mem_rdata = 0;
    bus.d_req = 1; bus.d_addr = 32'h300; bus.d_access_size = 0; bus.d_access_type = 0;
    tick();
    chk("t5_mreq", bus.mem_req, 1);
    #2;
    rst_n = 1'b0; bus.d_req = 0;
    #1;
    chk("t5_async_drop", bus.mem_req, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.mem_ack = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.d_ack || bus.if_ack || bus.mem_req) cnt++;
    end
    chk("t5_no_activity", cnt, 0);
    bus.mem_ack = 0;
    bus.d_req = 1; bus.d_addr = 32'h304;
    tick();
    chk("t5_mreq2", bus.mem_req, 1);
    chk("t5_addr2", bus.mem_addr, 32'h304);
    bus.mem_ack = 1; bus.mem_rdata = 32'hA5A55A5A;
    tick();
    chk("t5_d_ack", bus.d_ack, 1);
    chk("t5_d_rdata", bus.d_rdata, 32'hA5A55A5A);
    bus.mem_ack = 0; bus.d_req = 0;
    tick();

    // mem_ack in the 4th mem_req cycle beats the timeout
    bus.if_req = 1; bus.if_addr = 32'h8;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_mreq_c%0d", i), bus.mem_req, 1);
    end
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BADF00D;
    tick();
    chk("t6_if_ack", bus.if_ack, 1);
    chk("t6_if_err", bus.if_err, 0);
    chk("t6_if_rdata", bus.if_rdata, 32'h0BADF00D);
    chk("t6_mreq", bus.mem_req, 0);
    bus.mem_ack = 0; bus.if_req = 0;
    tick();
    chk("t6_pulse", bus.if_ack, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
